// File: rtl/signal_phase_countdown.sv
// signal_phase_countdown
//   Two-road traffic phase controller. A loadable down-counter times each
//   phase in enable ticks; when it reaches zero the six-state phase machine
//   advances and the counter reloads with the next phase's duration minus one.
//   A latched pedestrian request shortens the active green to PED_T+1 ticks.
//
// State table:
//   AR_NS (0) | all red, clearing before north-south green
//   NS_G  (1) | north-south green, east-west red
//   NS_Y  (2) | north-south yellow, east-west red
//   AR_EW (3) | all red, clearing before east-west green
//   EW_G  (4) | east-west green, north-south red
//   EW_Y  (5) | east-west yellow, north-south red
//   6, 7      | illegal, recovered to AR_NS on the next clk
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   synchronous active-low reset
//   tick     in   one-cycle enable pulse per timing unit
//   ped_req  in   pedestrian request (level or pulse)
//   ns_light out  north-south lamps {red,yellow,green}
//   ew_light out  east-west lamps {red,yellow,green}
//   remain   out  ticks left in current phase minus one
//   phase    out  current phase code
//   ped_pend out  pedestrian request latched, not yet served
module signal_phase_countdown #(
  parameter int GREEN_T  = 10,
  parameter int YELLOW_T = 3,
  parameter int RED_T    = 2,
  parameter int PED_T    = 2,
  parameter int CW       = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tick,
  input  logic          ped_req,
  output logic [2:0]    ns_light,
  output logic [2:0]    ew_light,
  output logic [CW-1:0] remain,
  output logic [2:0]    phase,
  output logic          ped_pend
);

  typedef enum logic [2:0] {
    AR_NS = 3'd0,
    NS_G  = 3'd1,
    NS_Y  = 3'd2,
    AR_EW = 3'd3,
    EW_G  = 3'd4,
    EW_Y  = 3'd5
  } phase_e;

  localparam logic [CW-1:0] LD_GREEN  = CW'(GREEN_T - 1);
  localparam logic [CW-1:0] LD_YELLOW = CW'(YELLOW_T - 1);
  localparam logic [CW-1:0] LD_RED    = CW'(RED_T - 1);
  localparam logic [CW-1:0] PED_V     = CW'(PED_T);
  localparam logic [CW-1:0] ONE       = CW'(1);

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  phase_e        phase_q, phase_d;
  logic [CW-1:0] remain_q, remain_d;
  logic [2:0]    ns_q, ns_d;
  logic [2:0]    ew_q, ew_d;
  logic          ped_q, ped_d;
  logic          is_green;

  function automatic phase_e next_of(input phase_e p);
    case (p)
      AR_NS:   next_of = NS_G;
      NS_G:    next_of = NS_Y;
      NS_Y:    next_of = AR_EW;
      AR_EW:   next_of = EW_G;
      EW_G:    next_of = EW_Y;
      default: next_of = AR_NS;
    endcase
  endfunction

  function automatic logic [CW-1:0] load_of(input phase_e p);
    case (p)
      NS_G, EW_G: load_of = LD_GREEN;
      NS_Y, EW_Y: load_of = LD_YELLOW;
      default:    load_of = LD_RED;
    endcase
  endfunction

  function automatic logic [2:0] ns_lamp(input phase_e p);
    case (p)
      NS_G:    ns_lamp = LAMP_GREEN;
      NS_Y:    ns_lamp = LAMP_YELLOW;
      default: ns_lamp = LAMP_RED;
    endcase
  endfunction

  function automatic logic [2:0] ew_lamp(input phase_e p);
    case (p)
      EW_G:    ew_lamp = LAMP_GREEN;
      EW_Y:    ew_lamp = LAMP_YELLOW;
      default: ew_lamp = LAMP_RED;
    endcase
  endfunction

  always_comb begin
    phase_d  = phase_q;
    remain_d = remain_q;
    ped_d    = ped_q | ped_req;
    is_green = (phase_q == NS_G) || (phase_q == EW_G);

    if (phase_q > EW_Y) begin
      phase_d  = AR_NS;
      remain_d = LD_RED;
    end else if (tick) begin
      if (remain_q == '0) begin
        phase_d  = next_of(phase_q);
        remain_d = load_of(phase_d);
        // Green ending serves the request; a request on this same edge is dropped.
        if (is_green) ped_d = 1'b0;
      end else if (is_green && ped_q && (remain_q > PED_V)) begin
        remain_d = PED_V;
      end else begin
        remain_d = remain_q - ONE;
      end
    end

    // Lamps are decoded from the next phase so they switch on the same edge.
    ns_d = ns_lamp(phase_d);
    ew_d = ew_lamp(phase_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q  <= AR_NS;
      remain_q <= LD_RED;
      ns_q     <= LAMP_RED;
      ew_q     <= LAMP_RED;
      ped_q    <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      remain_q <= remain_d;
      ns_q     <= ns_d;
      ew_q     <= ew_d;
      ped_q    <= ped_d;
    end
  end

  assign ns_light = ns_q;
  assign ew_light = ew_q;
  assign remain   = remain_q;
  assign phase    = phase_q;
  assign ped_pend = ped_q;

endmodule

// File: tb/tb_signal_phase_countdown.sv
module tb_signal_phase_countdown;

  localparam int GREEN_T  = 10;
  localparam int YELLOW_T = 3;
  localparam int RED_T    = 2;
  localparam int PED_T    = 2;
  localparam int CW       = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tick = 1'b0;
  logic          ped_req = 1'b0;
  logic [2:0]    ns_light, ew_light;
  logic [CW-1:0] remain;
  logic [2:0]    phase;
  logic          ped_pend;

  int n_tests = 0;
  int n_fail  = 0;

  signal_phase_countdown #(
    .GREEN_T(GREEN_T), .YELLOW_T(YELLOW_T), .RED_T(RED_T),
    .PED_T(PED_T), .CW(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .ped_req(ped_req),
    .ns_light(ns_light), .ew_light(ew_light), .remain(remain),
    .phase(phase), .ped_pend(ped_pend)
  );

  always #5 clk = ~clk;

  // Lamp expectations per phase 0..5: red=4, yellow=2, green=1
  int ns_tab[6] = '{4, 1, 2, 4, 4, 4};
  int ew_tab[6] = '{4, 4, 4, 4, 1, 2};
  int dur_tab[6] = '{RED_T, GREEN_T, YELLOW_T, RED_T, GREEN_T, YELLOW_T};

  typedef struct {
    logic r;
    logic t;
    logic p;
    int   ph;
    int   rem;
    int   pp;
  } vec_t;

  vec_t tbl[25];

  // Reference model: tracks whole ticks left in the current phase.
  int m_phase, m_left, m_ped;

  task automatic model_step(input logic r, input logic t, input logic p);
    int clr;
    bit grn;
    clr = 0;
    if (!r) begin
      m_phase = 0; m_left = RED_T; m_ped = 0;
      return;
    end
    grn = (m_phase == 1) || (m_phase == 4);
    if (t) begin
      if (m_left == 1) begin
        if (grn) clr = 1;
        m_phase = (m_phase + 1) % 6;
        m_left  = dur_tab[m_phase];
      end else if (grn && m_ped != 0 && (m_left - 1) > PED_T) begin
        m_left = PED_T + 1;
      end else begin
        m_left = m_left - 1;
      end
    end
    m_ped = clr ? 0 : ((m_ped != 0 || p) ? 1 : 0);
  endtask

  task automatic apply(input logic r, input logic t, input logic p);
    rst_n = r; tick = t; ped_req = p;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int idx, input int eph,
                     input int erem, input int epp);
    n_tests++;
    if (int'(phase) != eph || int'(remain) != erem || int'(ped_pend) != epp ||
        int'(ns_light) != ns_tab[eph] || int'(ew_light) != ew_tab[eph]) begin
      n_fail++;
      $display("FAIL %s[%0d]: got phase=%0d remain=%0d ped=%0d ns=%b ew=%b, want phase=%0d remain=%0d ped=%0d ns=%0d ew=%0d",
               name, idx, phase, remain, ped_pend, ns_light, ew_light,
               eph, erem, epp, ns_tab[eph], ew_tab[eph]);
    end
  endtask

  task automatic chk_lamps(input int idx);
    n_tests++;
    if (!$onehot(ns_light) || !$onehot(ew_light) ||
        (ns_light != 3'b100 && ew_light != 3'b100)) begin
      n_fail++;
      $display("FAIL lamp_safety[%0d]: got ns=%b ew=%b, want one-hot with at least one red",
               idx, ns_light, ew_light);
    end
  endtask

  initial begin
    // r, t, p, phase, remain, ped
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 0, 1, 0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 0, 0, 0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1, 9, 0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 1, 8, 0};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 1, 7, 0};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 1, 7, 1};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 1, 2, 1};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 1, 1, 1};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 1, 0, 1};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 2, 2, 0};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 2, 1, 1};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 2, 0, 1};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 3, 1, 1};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 3, 0, 1};
    tbl[14] = '{1'b1, 1'b1, 1'b0, 4, 9, 1};
    tbl[15] = '{1'b1, 1'b1, 1'b0, 4, 2, 1};
    tbl[16] = '{1'b1, 1'b1, 1'b0, 4, 1, 1};
    tbl[17] = '{1'b1, 1'b0, 1'b1, 4, 1, 1};
    tbl[18] = '{1'b1, 1'b1, 1'b0, 4, 0, 1};
    tbl[19] = '{1'b1, 1'b1, 1'b1, 5, 2, 0};
    tbl[20] = '{1'b1, 1'b1, 1'b0, 5, 1, 0};
    tbl[21] = '{1'b1, 1'b1, 1'b0, 5, 0, 0};
    tbl[22] = '{1'b1, 1'b1, 1'b0, 0, 1, 0};
    tbl[23] = '{1'b1, 1'b1, 1'b0, 0, 0, 0};
    tbl[24] = '{1'b1, 1'b1, 1'b0, 1, 9, 0};

    for (int i = 0; i < 25; i++) begin
      apply(tbl[i].r, tbl[i].t, tbl[i].p);
      chk("table", i, tbl[i].ph, tbl[i].rem, tbl[i].pp);
    end

    // Request when remain=1 in NS_G: no cut, cleared entering NS_Y.
    apply(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) apply(1'b1, 1'b1, 1'b0);
    chk("late_ped_pre", 0, 1, 1, 0);
    apply(1'b1, 1'b0, 1'b1);
    chk("late_ped_latch", 0, 1, 1, 1);
    apply(1'b1, 1'b1, 1'b0);
    chk("late_ped_nocut", 0, 1, 0, 1);
    apply(1'b1, 1'b1, 1'b0);
    chk("late_ped_yellow", 0, 2, 2, 0);

    // Reset mid EW_G with a pending request and tick high.
    apply(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 21; i++) apply(1'b1, 1'b1, 1'b0);
    chk("mid_rst_pre", 0, 4, 5, 0);
    apply(1'b1, 1'b0, 1'b1);
    chk("mid_rst_ped", 0, 4, 5, 1);
    apply(1'b0, 1'b1, 1'b1);
    chk("mid_rst", 0, 0, 1, 0);

    // No tick: everything holds.
    for (int i = 0; i < 20; i++) begin
      apply(1'b1, 1'b0, 1'b0);
      chk("hold", i, 0, 1, 0);
    end

    // Every-4th-clk tick pattern over two full cycles, checked against model.
    apply(1'b0, 1'b0, 1'b0);
    model_step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 240; i++) begin
      logic t;
      t = ((i % 4) == 3);
      apply(1'b1, t, 1'b0);
      model_step(1'b1, t, 1'b0);
      chk("slow_tick", i, m_phase, m_left - 1, m_ped);
      chk_lamps(i);
    end

    // Randomized run against the model.
    apply(1'b0, 1'b0, 1'b0);
    model_step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      logic r, t, p;
      r = ($urandom_range(0, 399) != 0);
      t = ($urandom_range(0, 2) == 0);
      p = ($urandom_range(0, 24) == 0);
      apply(r, t, p);
      model_step(r, t, p);
      chk("random", i, m_phase, m_left - 1, m_ped);
      chk_lamps(i);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/signal_phase_countdown.md
Name: signal_phase_countdown

Overview:
- Sequential two-road traffic phase controller built around a loadable down-counter.
- The counter decrements a phase timer once per enable tick and advances a six-state phase machine when it reaches zero.
- It drives lamp outputs for the north-south and east-west approaches and exposes the remaining time for a countdown display.
- A latched pedestrian request shortens the active green.

Parameters:
- GREEN_T, 10, green phase duration in ticks (1..2^CW)
- YELLOW_T, 3, yellow phase duration in ticks (1..2^CW)
- RED_T, 2, all-red clearance duration in ticks (1..2^CW)
- PED_T, 2, green ticks remaining after a pedestrian cut (0..GREEN_T-1)
- CW, 4, counter width in bits

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- tick  input  1  one-cycle enable pulse, one per timing unit
- ped_req  input  1  pedestrian request, level or pulse, sampled every clk
- ns_light  output  3  north-south lamps {red,yellow,green}, one-hot
- ew_light  output  3  east-west lamps {red,yellow,green}, one-hot
- remain  output  CW  ticks left in current phase minus one
- phase  output  3  current state encoding
- ped_pend  output  1  pedestrian request latched, not yet served

Behaviour:
- Clocking and reset:
  - One clock. Reset is synchronous and active-low.
  - rst_n is sampled on the rising clk edge and has priority over tick and ped_req.
- Reset values:
  - phase = AR_NS (0).
  - remain = RED_T-1.
  - ns_light = 3'b100, ew_light = 3'b100.
  - ped_pend = 0.
- Phase encoding and lamps:
  - AR_NS=0: ns red, ew red.
  - NS_G=1: ns green, ew red.
  - NS_Y=2: ns yellow, ew red.
  - AR_EW=3: ns red, ew red.
  - EW_G=4: ns red, ew green.
  - EW_Y=5: ns red, ew yellow.
  - Codes 6 and 7 are illegal. They force AR_NS with remain = RED_T-1 on the next clk.
- Transition order: AR_NS -> NS_G -> NS_Y -> AR_EW -> EW_G -> EW_Y -> AR_NS.
- Lamps are registered decodes of phase and change on the same clk edge as phase. Never two greens; never green plus yellow on one road.
- Counter, on a clk edge with tick=1 (checked in this priority):
  - remain==0: advance phase and load remain = duration(next)-1.
  - Otherwise, if phase is NS_G or EW_G, ped_pend=1 and remain>PED_T: remain = PED_T (cut).
  - Otherwise: remain = remain-1.
- With tick=0, remain and phase hold.
- A phase of duration D lasts exactly D ticks.
- Arithmetic is unsigned CW-bit. Decrement never wraps because the zero check precedes it.
- Pedestrian latch:
  - ped_pend sets on any clk edge with ped_req=1.
  - ped_pend clears on the edge where a green phase advances to yellow.
  - If set and cleared on the same edge, clear wins. A request arriving in the last green tick is dropped.
  - A request during yellow or all-red stays pending and cuts the next green.
- Cut rule:
  - A cut happens at most once per green, because afterwards remain<=PED_T.
  - If remain<=PED_T already, no cut occurs and normal decrement continues.
- Latency:
  - tick -> remain/phase/lamp update: 1 clk.
  - ped_req -> ped_pend: 1 clk.
- Reset mid-phase returns to AR_NS on the next edge regardless of tick, discarding any pending request.

Test Plan:
- Reset then tick every 4th clk, defaults, no ped_req -> phase sequence 0,1,2,3,4,5,0. Tick counts per phase are 2,10,3,2,10,3 (full cycle 30 ticks). remain goes 1,0 in AR_NS and 9..0 in NS_G.
- ped_req pulse in NS_G when remain=7 -> ped_pend=1 next clk. On the next tick remain=2, then 1,0, then NS_Y. ped_pend=0 on entering NS_Y.
- ped_req in NS_G when remain=1 -> no cut (1<=PED_T), normal advance. ped_pend cleared entering NS_Y.
- ped_req during NS_Y -> ped_pend stays 1 through AR_EW. The first EW_G tick takes remain from 9 to 2.
- rst_n low for one clk while in EW_G with remain=5 and tick=1 -> next state phase=0, remain=1, ns_light=ew_light=3'b100, ped_pend=0.
- Every clk of a full run -> ns_light and ew_light are always one-hot. They are never both non-red. tick=0 for 20 clks causes no change.
